core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl.sv | 155 +++++++++++++++
 tb/tb_core_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// Sequencer for the attention core: writes Q/K, loads K, executes, drains psums into pmem
// and reads them back out. A single phase counter is reused by every state.
module core_ctrl #(
    parameter int NQ  = 8,
    parameter int NK  = 8,
    parameter int GAP = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [16:0] inst,
    output logic        busy,
    output logic        out_valid,
    output logic [3:0]  out_idx,
    output logic        done,
    output logic [3:0]  state_dbg_o
);

    // Handshake: a host word is transferred on a rising edge where in_valid & in_ready;
    // in_ready is high only in QWR/KWR and never depends on in_valid.

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_QWR   = 4'd1,
        S_KWR   = 4'd2,
        S_KLOAD = 4'd3,
        S_GAP1  = 4'd4,
        S_EXEC  = 4'd5,
        S_GAP2  = 4'd6,
        S_DRAIN = 4'd7,
        S_PRD   = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    localparam logic [7:0] NQ_LAST  = 8'(NQ - 1);
    localparam logic [7:0] NK_LAST  = 8'(NK - 1);
    localparam logic [7:0] NK_CNT   = 8'(NK);
    localparam logic [7:0] KL_LAST  = 8'(NK + 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_idx_q, out_idx_d;

    logic       ofifo_rd, execute, load, qmem_rd, qmem_wr;
    logic       kmem_rd, kmem_wr, pmem_rd, pmem_wr;
    logic [3:0] qkmem_add, pmem_add;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Any transition clears the counter so each phase starts its index at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_QWR;
            S_QWR: if (in_valid) begin
                if (cnt_q == NQ_LAST) state_d = S_KWR;
                else                  cnt_d   = cnt_q + 8'd1;
            end
            S_KWR: if (in_valid) begin
                if (cnt_q == NK_LAST) state_d = S_KLOAD;
                else                  cnt_d   = cnt_q + 8'd1;
            end
            S_KLOAD: if (cnt_q == KL_LAST)  state_d = S_GAP1;  else cnt_d = cnt_q + 8'd1;
            S_GAP1:  if (cnt_q == GAP_LAST) state_d = S_EXEC;  else cnt_d = cnt_q + 8'd1;
            S_EXEC:  if (cnt_q == NQ_LAST)  state_d = S_GAP2;  else cnt_d = cnt_q + 8'd1;
            S_GAP2:  if (cnt_q == GAP_LAST) state_d = S_DRAIN; else cnt_d = cnt_q + 8'd1;
            S_DRAIN: if (cnt_q == NQ_LAST)  state_d = S_PRD;   else cnt_d = cnt_q + 8'd1;
            S_PRD:   if (cnt_q == NQ_LAST)  state_d = S_DONE;  else cnt_d = cnt_q + 8'd1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        ofifo_rd  = 1'b0;
        execute   = 1'b0;
        load      = 1'b0;
        qmem_rd   = 1'b0;
        qmem_wr   = 1'b0;
        kmem_rd   = 1'b0;
        kmem_wr   = 1'b0;
        pmem_rd   = 1'b0;
        pmem_wr   = 1'b0;
        qkmem_add = '0;
        pmem_add  = '0;
        in_ready  = 1'b0;
        unique case (state_q)
            S_QWR: begin
                in_ready  = 1'b1;
                qmem_wr   = in_valid;
                qkmem_add = cnt_q[3:0];
            end
            S_KWR: begin
                in_ready  = 1'b1;
                kmem_wr   = in_valid;
                qkmem_add = cnt_q[3:0];
            end
            S_KLOAD: begin
                load = 1'b1;
                // First and last cycles of the load window carry no kmem read.
                if (cnt_q >= 8'd1 && cnt_q <= NK_CNT) begin
                    kmem_rd   = 1'b1;
                    qkmem_add = 4'(cnt_q - 8'd1);
                end
            end
            S_EXEC: begin
                execute   = 1'b1;
                qmem_rd   = 1'b1;
                qkmem_add = cnt_q[3:0];
            end
            S_DRAIN: begin
                ofifo_rd = 1'b1;
                pmem_wr  = 1'b1;
                pmem_add = cnt_q[3:0];
            end
            S_PRD: begin
                pmem_rd  = 1'b1;
                pmem_add = cnt_q[3:0];
            end
            default: ;
        endcase
    end

    // pmem has one cycle of read latency, so the row flag trails pmem_rd by one cycle.
    assign out_valid_d = (state_q == S_PRD);
    assign out_idx_d   = (state_q == S_PRD) ? cnt_q[3:0] : 4'd0;

    assign inst = {ofifo_rd, qkmem_add, pmem_add, execute, load,
                   qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr};

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: full sequences with stalls, ignored start, mid-run reset.
module tb_core_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] inst;
    logic        busy;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic        done;
    logic [3:0]  state_dbg;

    int n_checks;
    int n_fail;

    core_ctrl #(.NQ(8), .NK(8), .GAP(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inst       (inst),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .done       (done),
        .state_dbg_o(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] mk(input logic ofifo, input logic [3:0] qk, input logic [3:0] pa,
                                       input logic ex, input logic ld, input logic qr, input logic qw,
                                       input logic kr, input logic kw, input logic pr, input logic pw);
        return {ofifo, qk, pa, ex, ld, qr, qw, kr, kw, pr, pw};
    endfunction

    // Hand-written timeline for NQ=NK=8, GAP=10; n is the nominal cycle (1 = first QWR cycle).
    function automatic logic [16:0] exp_inst(input int n);
        int k;
        if (n >= 1 && n <= 8)   return mk(0, 4'(n - 1), 0, 0, 0, 0, 1, 0, 0, 0, 0);
        if (n >= 9 && n <= 16)  return mk(0, 4'(n - 9), 0, 0, 0, 0, 0, 0, 1, 0, 0);
        if (n >= 17 && n <= 26) begin
            k = n - 17;
            if (k >= 1 && k <= 8) return mk(0, 4'(k - 1), 0, 0, 1, 0, 0, 1, 0, 0, 0);
            return mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        end
        if (n >= 37 && n <= 44) return mk(0, 4'(n - 37), 0, 1, 0, 1, 0, 0, 0, 0, 0);
        if (n >= 55 && n <= 62) return mk(1, 0, 4'(n - 55), 0, 0, 0, 0, 0, 0, 0, 1);
        if (n >= 63 && n <= 70) return mk(0, 0, 4'(n - 63), 0, 0, 0, 0, 0, 0, 1, 0);
        return 17'd0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_inst"},      32'(inst), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_idx"},   32'(out_idx), 32'd0);
        check({tag, "_done"},      32'(done), 32'd0);
    endtask

    // Driver: runs one sequence; optional 3+ cycle stall after Q word 2, start pulse at a
    // nominal cycle, or reset at a nominal cycle (which aborts and returns).
    task automatic run_seq(input int stall_len, input int start_at, input int abort_at);
        int  n;
        int  stall_left;
        logic stalled;
        n = 1;
        stall_left = stall_len;
        @(posedge clk); #1;
        start = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n <= 71) begin
            stalled  = (n == 4) && (stall_left > 0);
            in_valid = !stalled;
            start    = (n == start_at) && !stalled;
            if (n == abort_at) begin
                #2 reset = 1'b1;
                #1 check_idle("reset_async");
                @(posedge clk); @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_idle("after_reset");
                end
                return;
            end
            @(negedge clk);
            if (stalled) begin
                check("stall_inst", 32'(inst), 32'(mk(0, 4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
                check("stall_ready", 32'(in_ready), 32'd1);
            end else begin
                check("inst", 32'(inst), 32'(exp_inst(n)));
                check("in_ready", 32'(in_ready), 32'(n <= 16));
            end
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'(n == 71));
            check("out_valid", 32'(out_valid), 32'(n >= 64 && n <= 71));
            if (n >= 64 && n <= 71) check("out_idx", 32'(out_idx), 32'(n - 64));
            @(posedge clk); #1;
            if (stalled) stall_left--;
            else n++;
        end
        start = 1'b0;
        @(negedge clk);
        check_idle("post_done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        #1 check_idle("reset_state");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("idle_no_start");

        run_seq(0, 0, 0);    // nominal sequence, done at cycle 71
        run_seq(3, 0, 0);    // 3-cycle Q stall, done 3 cycles later
        run_seq(0, 40, 0);   // start during EXEC ignored
        run_seq(0, 0, 40);   // reset during EXEC aborts
        run_seq(0, 0, 0);    // clean sequence after abort

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
